router_pkt_tx: RTL and testbench
================================

# router_pkt_tx

Packet transmitter for the 1x3 router input port. It collects a payload from a local byte stream into an internal 63-byte buffer, then serialises it on the router's `pkt_valid`/`data_in` interface, honouring `busy` backpressure:
- header byte `{length[5:0], dest[1:0]}`
- payload bytes
- XOR parity byte

It sits upstream of `router_top`, and its outputs drive the router's `data_in` and `pkt_valid` directly.

## Interface
- `IDLE_GAP`, default 2: minimum idle cycles after a parity byte before the next packet is accepted. Legal range 0..15.

Ports:
- `clock` in 1: sole clock; all state changes on the rising edge.
- `resetn` in 1: reset, synchronous and active-high despite the name; 1 resets the block.
- `start` in 1: packet request, sampled only while `tx_ready`=1.
- `dest` in 2: destination port 0..2, captured with `start`.
- `length` in 6: payload length 1..63, captured with `start`.
- `tx_ready` out 1: block is idle and a `start` will be accepted.
- `pay_data` in 8: payload byte.
- `pay_valid` in 1: `pay_data` valid.
- `pay_ready` out 1: payload byte is accepted when `pay_valid` & `pay_ready`.
- `busy` in 1: router backpressure.
- `pkt_valid` out 1: to router `pkt_valid`.
- `tx_data` out 8: to router `data_in`.
- `done` out 1: one-cycle pulse, parity byte transferred.
- `req_err` out 1: one-cycle pulse, request rejected.
- `corrupt_parity` in 1: present only with `ROUTER_TX_PARITY_ERR_EN`.

## Operation
- FSM states are IDLE, LOAD, HEADER, PAYLOAD, PARITY and GAP.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- **IDLE**
  - Outputs: `tx_ready`=1, `pkt_valid`=0, `tx_data`=00.
  - `start` with `dest`≠3 and `length`≠0 latches `dest`/`length`, initialises parity to the header byte, and moves to LOAD.
  - `start` with `dest`=3 or `length`=0 pulses `req_err` the next cycle; the FSM stays in IDLE.
- **LOAD**
  - `pay_ready`=1.
  - Each accepted byte is written to `buf[wr_cnt]`, XORed into parity, and `wr_cnt` increments.
  - When `wr_cnt` reaches `length`, go to HEADER.
  - `pay_valid` gaps are allowed and simply extend LOAD.
- **HEADER**
  - Outputs: `pkt_valid`=1, `tx_data`=header.
- **PAYLOAD**
  - Outputs: `pkt_valid`=1, `tx_data`=`buf[rd_cnt]`.
  - `rd_cnt` increments on each beat.
  - After the beat with `rd_cnt`=`length`-1, go to PARITY.
- **PARITY**
  - Outputs: `pkt_valid`=0, `tx_data`=parity.
  - On its beat, pulse `done` and go to GAP.
- **GAP**
  - Outputs: `pkt_valid`=0, `tx_data`=00.
  - Lasts `IDLE_GAP` cycles, then IDLE. With `IDLE_GAP`=0, go PARITY→IDLE directly.
- **Beat:** a rising edge in HEADER, PAYLOAD or PARITY with `busy`=0.
  - With `busy`=1, `tx_data`/`pkt_valid` are held unchanged; no byte is skipped or duplicated.
- **Parity:** header ^ all payload bytes. Only 8-bit XOR is used, with no carries.
- **Ignored inputs:**
  - `start` outside IDLE is ignored.
  - `pay_valid` outside LOAD is ignored, because `pay_ready`=0 there.
- **Counters:** 6-bit; `wr_cnt`/`rd_cnt` never exceed `length`, so the buffer never wraps.

## Timing
- **Reset values:** state IDLE, `tx_ready`=1, `pay_ready`=0, `pkt_valid`=0, `tx_data`=00, `done`=0, `req_err`=0, counters 0.
- **Reset mid-packet:** the packet is aborted. The cycle after `resetn` is sampled high, `pkt_valid`=0 and `tx_data`=00, leaving the router with a truncated packet (intended).
- **Start to payload:** `start` accepted at edge N → `pay_ready`=1 from cycle N+1.
- **Header:** the header appears the cycle after the last payload byte is accepted.
- **Packet duration:** with `busy` held 0, HEADER + PAYLOAD occupy exactly `length`+1 cycles of `pkt_valid`=1, followed by 1 parity cycle.
- **`done`:** high in the cycle after the parity beat.
- **`busy` on the last payload beat:** if `busy` rises during the final payload byte, that byte is held; PARITY is entered only after its beat.

## Configuration
- **`ROUTER_TX_PARITY_ERR_EN` defined:**
  - `corrupt_parity` port exists and is latched with an accepted `start`.
  - If the latched value is 1, the transmitted parity byte is the true parity ^ 8'h01, to exercise the router `err` path.
- **Not defined:** the port is absent and parity is always correct.

## Test plan
- **Basic packet:** reset; `start` `dest`=1 `length`=3, payload A1,B2,C3 back-to-back, `busy`=0 → `tx_data` sequence 0D,A1,B2,C3 with `pkt_valid`=1, then DD with `pkt_valid`=0; `done` pulse; `tx_ready`=1 after 2 GAP cycles.
- **Header backpressure:** as above, with `busy`=1 for 3 cycles starting at HEADER → header 0D held 4 cycles, then A1,B2,C3,DD with no loss or duplication.
- **Rejected requests:** `start` `dest`=3 `length`=5 → `req_err` pulse, `pay_ready` stays 0, state IDLE; repeat with `dest`=0 `length`=0 → same result.
- **Maximum length:** `dest`=2 `length`=63 with payload 00..3E and random `pay_valid` gaps → header FE, 63 ordered payload beats, parity = FE ^ XOR(00..3E).
- **Reset mid-packet:** assert `resetn` during the PAYLOAD beat of byte index 5 → next cycle `pkt_valid`=0, `tx_data`=00, `tx_ready`=1; a following packet transmits correctly.
- **Parity corruption (macro defined):** basic packet with `corrupt_parity`=1 → parity byte DC; with 0 → DD.

Source files
------------

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - 1x3 router packet transmitter: buffers a payload, then sends header/payload/parity
// Optional `ROUTER_TX_PARITY_ERR_EN adds corrupt_parity to flip parity bit 0 for router error testing.
module router_pkt_tx #(
  parameter int IDLE_GAP = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] length,
  output logic       tx_ready,
  input  logic [7:0] pay_data,
  input  logic       pay_valid,
  output logic       pay_ready,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] tx_data,
  output logic       done,
  output logic       req_err
`ifdef ROUTER_TX_PARITY_ERR_EN
  ,
  input  logic       corrupt_parity
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);

  state_t     state;
  logic [5:0] wr_cnt;
  logic [5:0] rd_cnt;
  logic [3:0] gap_cnt;
  logic [1:0] dest_q;
  logic [5:0] len_q;
  logic [7:0] parity;
  logic [7:0] parity_tx;
  logic [7:0] pay_buf [0:62];

  wire load_accept = (state == LOAD) && pay_valid && pay_ready;

`ifdef ROUTER_TX_PARITY_ERR_EN
  logic corrupt_q;

  always_ff @(posedge clock) begin
    if (resetn)
      corrupt_q <= 1'b0;
    else if (state == IDLE && start && dest != 2'd3 && length != 6'd0)
      corrupt_q <= corrupt_parity;
  end

  assign parity_tx = parity ^ {7'd0, corrupt_q};
`else
  assign parity_tx = parity;
`endif

  // Payload storage has no reset; contents are only read after being written in LOAD.
  always_ff @(posedge clock) begin
    if (!resetn && load_accept)
      pay_buf[wr_cnt] <= pay_data;
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state     <= IDLE;
      tx_ready  <= 1'b1;
      pay_ready <= 1'b0;
      pkt_valid <= 1'b0;
      tx_data   <= 8'h00;
      done      <= 1'b0;
      req_err   <= 1'b0;
      wr_cnt    <= 6'd0;
      rd_cnt    <= 6'd0;
      gap_cnt   <= 4'd0;
      dest_q    <= 2'd0;
      len_q     <= 6'd0;
      parity    <= 8'h00;
    end else begin
      done    <= 1'b0;
      req_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (dest != 2'd3 && length != 6'd0) begin
              dest_q    <= dest;
              len_q     <= length;
              parity    <= {length, dest};
              wr_cnt    <= 6'd0;
              rd_cnt    <= 6'd0;
              tx_ready  <= 1'b0;
              pay_ready <= 1'b1;
              state     <= LOAD;
            end else begin
              req_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (load_accept) begin
            parity <= parity ^ pay_data;
            wr_cnt <= wr_cnt + 6'd1;
            if (wr_cnt + 6'd1 == len_q) begin
              pay_ready <= 1'b0;
              pkt_valid <= 1'b1;
              tx_data   <= {len_q, dest_q};
              state     <= HEADER;
            end
          end
        end
        HEADER: begin
          if (!busy) begin
            tx_data <= pay_buf[6'd0];
            rd_cnt  <= 6'd0;
            state   <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          // rd_cnt names the byte currently on tx_data; it ends at len_q, never past it.
          if (!busy) begin
            rd_cnt <= rd_cnt + 6'd1;
            if (rd_cnt == len_q - 6'd1) begin
              pkt_valid <= 1'b0;
              tx_data   <= parity_tx;
              state     <= PARITY;
            end else begin
              tx_data <= pay_buf[rd_cnt + 6'd1];
            end
          end
        end
        PARITY: begin
          if (!busy) begin
            done    <= 1'b1;
            tx_data <= 8'h00;
            gap_cnt <= 4'd0;
            if (IDLE_GAP == 0) begin
              tx_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            tx_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - self-checking bench for router_pkt_tx
// Covers parity corruption when ROUTER_TX_PARITY_ERR_EN is defined.
module tb_router_pkt_tx;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [1:0] dest;
  logic [5:0] length;
  logic       tx_ready;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_ready;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] tx_data;
  logic       done;
  logic       req_err;
  logic       corrupt_parity;

  int n_chk  = 0;
  int n_fail = 0;

  router_pkt_tx dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .dest      (dest),
    .length    (length),
    .tx_ready  (tx_ready),
    .pay_data  (pay_data),
    .pay_valid (pay_valid),
    .pay_ready (pay_ready),
    .busy      (busy),
    .pkt_valid (pkt_valid),
    .tx_data   (tx_data),
    .done      (done),
    .req_err   (req_err)
`ifdef ROUTER_TX_PARITY_ERR_EN
    ,
    .corrupt_parity (corrupt_parity)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       st;
    logic [1:0] de;
    logic [5:0] ln;
    logic       pv;
    logic [7:0] pd;
    logic       bz;
    logic       e_rdy;
    logic       e_prdy;
    logic       e_pkv;
    logic [7:0] e_dat;
    logic       e_done;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic [1:0] de, logic [5:0] ln, logic pv, logic [7:0] pd,
                              logic bz, logic e_rdy, logic e_prdy, logic e_pkv, logic [7:0] e_dat,
                              logic e_done, logic e_err);
    vec_t v;
    v.st = st; v.de = de; v.ln = ln; v.pv = pv; v.pd = pd; v.bz = bz;
    v.e_rdy = e_rdy; v.e_prdy = e_prdy; v.e_pkv = e_pkv; v.e_dat = e_dat;
    v.e_done = e_done; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_basic(input string tag, input logic cp, input logic [7:0] exp_par);
    logic [7:0] pl [3];
    pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
    start = 1'b1; dest = 2'd1; length = 6'd3; corrupt_parity = cp;
    tick();
    start = 1'b0; corrupt_parity = 1'b0;
    chk({tag, "_pay_ready"}, {7'd0, pay_ready}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      pay_valid = 1'b1; pay_data = pl[i];
      tick();
    end
    pay_valid = 1'b0;
    chk({tag, "_hdr"}, tx_data, 8'h0D);
    chk({tag, "_hdr_pv"}, {7'd0, pkt_valid}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("%s_pay%0d", tag, i), tx_data, pl[i]);
    end
    tick();
    chk({tag, "_parity"}, tx_data, exp_par);
    chk({tag, "_parity_pv"}, {7'd0, pkt_valid}, 8'h00);
    tick();
    chk({tag, "_done"}, {7'd0, done}, 8'h01);
    tick();
    tick();
    chk({tag, "_tx_ready"}, {7'd0, tx_ready}, 8'h01);
  endtask

  initial begin
    int acc;
    int cyc;
    resetn = 1'b1; start = 1'b0; dest = 2'd0; length = 6'd0;
    pay_data = 8'h00; pay_valid = 1'b0; busy = 1'b0; corrupt_parity = 1'b0;
    repeat (3) tick();
    resetn = 1'b0;
    chk("rst_tx_ready", {7'd0, tx_ready}, 8'h01);
    chk("rst_pay_ready", {7'd0, pay_ready}, 8'h00);
    chk("rst_pkt_valid", {7'd0, pkt_valid}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_done", {7'd0, done}, 8'h00);
    chk("rst_req_err", {7'd0, req_err}, 8'h00);

    // basic packet with a pay_valid gap; start/pay_valid outside their states are ignored
    vecs.push_back(mk(1, 1, 3, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'hA1, 0, 0, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'hEE, 0, 0, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'hB2, 0, 0, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'hC3, 0, 0, 0, 1, 8'h0D, 0, 0));
    vecs.push_back(mk(1, 2, 5, 1, 8'h55, 0, 0, 0, 1, 8'hA1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 8'hB2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 8'hC3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'hDD, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0));
    vecs.push_back(mk(1, 1, 3, 1, 8'h77, 0, 0, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0));
    // header held by busy for 3 cycles, plus busy mid-payload, on last byte and on parity
    vecs.push_back(mk(1, 1, 3, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'hA1, 0, 0, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'hB2, 0, 0, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'hC3, 0, 0, 0, 1, 8'h0D, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 1, 8'h0D, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 1, 8'h0D, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 1, 8'h0D, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 8'hA1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 8'hB2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 1, 8'hB2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 8'hC3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 1, 8'hC3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'hDD, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'hDD, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0));
    // rejected requests
    vecs.push_back(mk(1, 3, 5, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 8'h12, 0, 1, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 3, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st; dest = vecs[i].de; length = vecs[i].ln;
      pay_valid = vecs[i].pv; pay_data = vecs[i].pd; busy = vecs[i].bz;
      tick();
      chk($sformatf("v%0d_tx_ready", i), {7'd0, tx_ready}, {7'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d_pay_ready", i), {7'd0, pay_ready}, {7'd0, vecs[i].e_prdy});
      chk($sformatf("v%0d_pkt_valid", i), {7'd0, pkt_valid}, {7'd0, vecs[i].e_pkv});
      chk($sformatf("v%0d_tx_data", i), tx_data, vecs[i].e_dat);
      chk($sformatf("v%0d_done", i), {7'd0, done}, {7'd0, vecs[i].e_done});
      chk($sformatf("v%0d_req_err", i), {7'd0, req_err}, {7'd0, vecs[i].e_err});
    end
    start = 1'b0; pay_valid = 1'b0; busy = 1'b0;

    // maximum length with random pay_valid gaps
    start = 1'b1; dest = 2'd2; length = 6'd63;
    tick();
    start = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 63 && cyc < 2000) begin
      pay_valid = 1'($urandom_range(0, 1));
      pay_data = 8'(acc);
      if (pay_valid && pay_ready) acc++;
      tick();
      cyc++;
    end
    pay_valid = 1'b0;
    chk("max_load_count", 8'(acc), 8'd63);
    chk("max_hdr", tx_data, 8'hFE);
    chk("max_hdr_pv", {7'd0, pkt_valid}, 8'h01);
    for (int i = 0; i < 63; i++) begin
      tick();
      chk($sformatf("max_pay%0d", i), tx_data, 8'(i));
      chk($sformatf("max_pay%0d_pv", i), {7'd0, pkt_valid}, 8'h01);
    end
    tick();
    chk("max_parity", tx_data, 8'hC1);
    chk("max_parity_pv", {7'd0, pkt_valid}, 8'h00);
    tick();
    chk("max_done", {7'd0, done}, 8'h01);
    tick();
    tick();
    chk("max_tx_ready", {7'd0, tx_ready}, 8'h01);

    // reset while payload byte 5 is on the bus
    start = 1'b1; dest = 2'd0; length = 6'd8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pay_valid = 1'b1; pay_data = 8'h10 + 8'(i);
      tick();
    end
    pay_valid = 1'b0;
    repeat (6) tick();
    chk("rst_mid_byte5", tx_data, 8'h15);
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    chk("rst_mid_pkt_valid", {7'd0, pkt_valid}, 8'h00);
    chk("rst_mid_tx_data", tx_data, 8'h00);
    chk("rst_mid_tx_ready", {7'd0, tx_ready}, 8'h01);
    chk("rst_mid_pay_ready", {7'd0, pay_ready}, 8'h00);
    tick();
    send_basic("post_rst", 1'b0, 8'hDD);

`ifdef ROUTER_TX_PARITY_ERR_EN
    send_basic("corrupt1", 1'b1, 8'hDC);
    send_basic("corrupt0", 1'b0, 8'hDD);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
